// File: rtl/ls1u_bus_pkg.sv
// Shared definitions for the LS1U bus unit.
// Holds the FSM state encoding and the transfer-type codes, so the unit and
// anything that inspects it agree on one encoding.
package ls1u_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StAddr,
    StData,
    StDone
  } state_t;

  typedef enum logic [1:0] {
    XferWrite,
    XferRead,
    XferLine
  } xfer_t;

endpackage

// File: rtl/ls1u_bus_unit_if.sv
// Bus-side signal bundle of the LS1U bus unit.
// master: the bus unit (drives address/control/write data, bus_req, hreset_n)
// slave : the bus slave + arbiter (drives hready, hresp, hrdata, bus_ack)
interface ls1u_bus_unit_if #(
  parameter int unsigned BUS_ADDR = 24
) ();

  logic [BUS_ADDR-1:0] haddr;
  logic                hwrite;
  logic                hburst;
  logic                htrans;
  logic [7:0]          hwdata;
  logic                hready;
  logic                hresp;
  logic                hreset_n;
  logic [7:0]          hrdata;
  logic                bus_ack;
  logic                bus_req;

  modport master (
    output haddr, hwrite, hburst, htrans, hwdata, hreset_n, bus_req,
    input  hready, hresp, hrdata, bus_ack
  );

  modport slave (
    input  haddr, hwrite, hburst, htrans, hwdata, hreset_n, bus_req,
    output hready, hresp, hrdata, bus_ack
  );

endinterface

// File: rtl/ls1u_bus_unit.sv
// LS1U bus unit: turns cache requests (single-byte write-through, single-byte
// read, line burst read) into non-overlapped address/data phase bus cycles.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   write_through_req          single-byte write request (highest priority)
//   read_line_req              line (burst) read request
//   read_req                   single-byte read request (lowest priority)
//   pa, wt_data                transaction address and write byte
//   line_data, addr_count      captured read byte and its beat index
//   line_write                 one-cycle strobe per good line-read beat
//   trans_rdy, bus_error       completion pulse and failure flag
//   bus                        bus-side signals (master modport)
module ls1u_bus_unit
  import ls1u_bus_pkg::*;
#(
  parameter int unsigned BUS_ADDR  = 24,
  parameter int unsigned MAX_BURST = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write_through_req,
  input  logic                read_req,
  input  logic                read_line_req,
  input  logic [BUS_ADDR-1:0] pa,
  input  logic [7:0]          wt_data,
  output logic [7:0]          line_data,
  output logic [7:0]          addr_count,
  output logic                line_write,
  output logic                trans_rdy,
  output logic                bus_error,
  ls1u_bus_unit_if.master     bus
);

  localparam int unsigned BeatW = $clog2(MAX_BURST);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(MAX_BURST - 1);

  state_t              r_state;
  xfer_t               r_type;
  logic [BUS_ADDR-1:0] r_pa;
  logic [7:0]          r_wdata;
  logic [BeatW-1:0]    r_beat;
  logic [BUS_ADDR-1:0] r_haddr;
  logic                r_hwrite;
  logic                r_hburst;
  logic                r_htrans;
  logic [7:0]          r_hwdata;
  logic                r_bus_req;
  logic [7:0]          r_line_data;
  logic [7:0]          r_addr_count;
  logic                r_line_write;
  logic                r_trans_rdy;
  logic                r_bus_error;

  logic [BeatW-1:0]    w_beat_inc;
  logic                w_any_req;

  assign w_beat_inc = r_beat + 1'b1;
  assign w_any_req  = write_through_req | read_line_req | read_req;

  // Outputs are registered together with the state, so each output value is
  // the one belonging to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_type       <= XferRead;
      r_pa         <= '0;
      r_wdata      <= '0;
      r_beat       <= '0;
      r_haddr      <= '0;
      r_hwrite     <= 1'b0;
      r_hburst     <= 1'b0;
      r_htrans     <= 1'b0;
      r_hwdata     <= '0;
      r_bus_req    <= 1'b0;
      r_line_data  <= '0;
      r_addr_count <= '0;
      r_line_write <= 1'b0;
      r_trans_rdy  <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_line_write <= 1'b0;
      r_trans_rdy  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (write_through_req) begin
            r_type <= XferWrite;
          end else if (read_line_req) begin
            r_type <= XferLine;
          end else begin
            r_type <= XferRead;
          end
          if (w_any_req) begin
            r_pa      <= pa;
            r_wdata   <= wt_data;
            r_beat    <= '0;
            r_bus_req <= 1'b1;
            r_state   <= StArb;
          end
        end
        StArb: begin
          if (bus.bus_ack) begin
            r_htrans <= 1'b1;
            r_hwrite <= (r_type == XferWrite);
            r_hburst <= (r_type == XferLine);
            // Burst beats walk the low address bits; r_beat is zero here.
            r_haddr  <= (r_type == XferLine) ? {r_pa[BUS_ADDR-1:BeatW], r_beat} : r_pa;
            r_state  <= StAddr;
          end
        end
        StAddr: begin
          if (bus.hready) begin
            r_htrans <= 1'b0;
            r_hwdata <= r_wdata;
            r_state  <= StData;
          end
        end
        StData: begin
          if (bus.hready) begin
            if (r_type != XferWrite) begin
              r_line_data  <= bus.hrdata;
              r_addr_count <= 8'(r_beat);
            end
            if (bus.hresp) begin
              // Error aborts the transfer (and any remaining burst beats).
              r_bus_error <= 1'b1;
              r_trans_rdy <= 1'b1;
              r_bus_req   <= 1'b0;
              r_hwrite    <= 1'b0;
              r_hburst    <= 1'b0;
              r_state     <= StDone;
            end else begin
              r_line_write <= (r_type == XferLine);
              if ((r_type == XferLine) && (r_beat != LastBeat)) begin
                r_beat   <= w_beat_inc;
                r_haddr  <= {r_pa[BUS_ADDR-1:BeatW], w_beat_inc};
                r_htrans <= 1'b1;
                r_state  <= StAddr;
              end else begin
                r_trans_rdy <= 1'b1;
                r_bus_req   <= 1'b0;
                r_hwrite    <= 1'b0;
                r_hburst    <= 1'b0;
                r_state     <= StDone;
              end
            end
          end
        end
        StDone: begin
          // Requests seen here are ignored; requesters drop them after trans_rdy.
          r_bus_error <= 1'b0;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.haddr    = r_haddr;
  assign bus.hwrite   = r_hwrite;
  assign bus.hburst   = r_hburst;
  assign bus.htrans   = r_htrans;
  assign bus.hwdata   = r_hwdata;
  assign bus.bus_req  = r_bus_req;
  assign bus.hreset_n = !rst;

  assign line_data  = r_line_data;
  assign addr_count = r_addr_count;
  assign line_write = r_line_write;
  assign trans_rdy  = r_trans_rdy;
  assign bus_error  = r_bus_error;

endmodule

// File: tb/tb_ls1u_bus_unit.sv
// Self-checking bench for ls1u_bus_unit (BUS_ADDR=24, MAX_BURST=4).
// The bench plays requester, arbiter and bus slave. For each transaction it
// pre-plans the grant delay and the hready pattern, then derives every
// expected output from the phase rules: ARB lasts until the grant, each
// ADDR/DATA phase ends on an hready=1 cycle, and DONE follows the last beat.
module tb_ls1u_bus_unit;

  localparam int unsigned BA = 24;
  localparam int unsigned MB = 4;
  localparam int KWrite = 0;
  localparam int KRead  = 1;
  localparam int KLine  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wtr, rr, rlr;
  logic [BA-1:0] pa;
  logic [7:0]    wt_data;
  logic [7:0]    line_data, addr_count;
  logic          line_write, trans_rdy, bus_error;

  int tests = 0;
  int fails = 0;
  int rd_fixed = -1;

  always #5 clk = ~clk;

  ls1u_bus_unit_if #(.BUS_ADDR(BA)) bus ();

  ls1u_bus_unit #(
    .BUS_ADDR (BA),
    .MAX_BURST(MB)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .write_through_req(wtr),
    .read_req         (rr),
    .read_line_req    (rlr),
    .pa               (pa),
    .wt_data          (wt_data),
    .line_data        (line_data),
    .addr_count       (addr_count),
    .line_write       (line_write),
    .trans_rdy        (trans_rdy),
    .bus_error        (bus_error),
    .bus              (bus.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".htrans"},     32'(bus.htrans),    32'd0);
    chk({tag, ".hwrite"},     32'(bus.hwrite),    32'd0);
    chk({tag, ".hburst"},     32'(bus.hburst),    32'd0);
    chk({tag, ".bus_req"},    32'(bus.bus_req),   32'd0);
    chk({tag, ".line_write"}, 32'(line_write),    32'd0);
    chk({tag, ".trans_rdy"},  32'(trans_rdy),     32'd0);
    chk({tag, ".bus_error"},  32'(bus_error),     32'd0);
    chk({tag, ".haddr"},      32'(bus.haddr),     32'd0);
    chk({tag, ".hwdata"},     32'(bus.hwdata),    32'd0);
    chk({tag, ".line_data"},  32'(line_data),     32'd0);
    chk({tag, ".addr_count"}, 32'(addr_count),    32'd0);
  endtask

  // kind: transfer type; w: grant delay in ARB cycles; mode: hready plan
  // (0 always ready, 1 random stalls, 2 two stalls in first ADDR and DATA);
  // err_beat: beat that gets hresp=1 (-1 none); hold_rd: also raise read_req
  // and keep it up after this transfer completes.
  task automatic run_xfer(input int kind, input logic [BA-1:0] a, input logic [7:0] wd,
                          input int w, input int mode, input int err_beat, input bit hold_rd);
    bit            hr[128];
    int            n_beats, n_eff, cend, cnt, p, beat;
    bit            err, in_x, adr_ph, exp_lw;
    logic [7:0]    lw_data, lw_cnt, last_rd;
    logic [BA-1:0] ea;

    n_beats = (kind == KLine) ? MB : 1;
    err     = (err_beat >= 0) && (err_beat < n_beats);
    n_eff   = err ? err_beat + 1 : n_beats;
    for (int k = 0; k < 128; k++) begin
      case (mode)
        0:       hr[k] = 1'b1;
        1:       hr[k] = (k >= 40) || ($urandom_range(0, 99) >= 30);
        default: hr[k] = !(k == 0 || k == 1 || k == 3 || k == 4);
      endcase
    end
    // The transfer ends on the hready=1 cycle that closes its last phase.
    cnt  = 0;
    cend = 0;
    for (int k = 0; k < 128; k++) begin
      if (hr[k] && cend == 0) begin
        cnt++;
        if (cnt == 2 * n_eff) cend = w + 2 + k;
      end
    end
    exp_lw  = 1'b0;
    lw_data = '0;
    lw_cnt  = '0;
    last_rd = '0;

    for (int c = 0; c <= cend + 1; c++) begin
      @(negedge clk);
      in_x = (c >= w + 2) && (c <= cend);
      p = 0;
      if (in_x) begin
        for (int k = 0; k < c - (w + 2); k++) if (hr[k]) p++;
      end
      adr_ph = in_x && (p % 2 == 0);
      beat   = p / 2;

      chk("bus_req", 32'(bus.bus_req), 32'(c >= 1 && c <= cend));
      chk("htrans", 32'(bus.htrans), 32'(adr_ph));
      if (adr_ph) begin
        ea = (kind == KLine) ? ((a & ~BA'(MB - 1)) | BA'(beat)) : a;
        chk("haddr", 32'(bus.haddr), 32'(ea));
        chk("hwrite", 32'(bus.hwrite), 32'(kind == KWrite));
      end
      if (in_x) chk("hburst", 32'(bus.hburst), 32'(kind == KLine));
      if (in_x && !adr_ph && kind == KWrite) chk("hwdata", 32'(bus.hwdata), 32'(wd));
      chk("line_write", 32'(line_write), 32'(exp_lw));
      if (exp_lw) begin
        chk("addr_count", 32'(addr_count), 32'(lw_cnt));
        chk("line_data", 32'(line_data), 32'(lw_data));
      end
      chk("trans_rdy", 32'(trans_rdy), 32'(c == cend + 1));
      if (c >= 1) chk("bus_error", 32'(bus_error), 32'((c == cend + 1) && err));
      if (c == cend + 1 && kind != KWrite) chk("line_data_hold", 32'(line_data), 32'(last_rd));

      // Drive inputs for the edge that ends cycle c.
      exp_lw = 1'b0;
      if (c == 0) begin
        pa      = a;
        wt_data = wd;
        wtr     = (kind == KWrite);
        rlr     = (kind == KLine);
        rr      = (kind == KRead) || hold_rd;
      end
      bus.bus_ack = (c >= w + 1);
      bus.hrdata  = 8'($urandom);
      bus.hready  = 1'($urandom);
      bus.hresp   = 1'($urandom);
      if (in_x) begin
        bus.hready = hr[c - (w + 2)];
        if (bus.hready && !adr_ph) begin
          if (rd_fixed >= 0) bus.hrdata = 8'(rd_fixed);
          bus.hresp = err && (beat == n_eff - 1);
          if (kind != KWrite) last_rd = bus.hrdata;
          exp_lw  = (kind == KLine) && !bus.hresp;
          lw_cnt  = 8'(beat);
          lw_data = bus.hrdata;
        end
      end
      if (c == cend + 1) begin
        wtr     = 1'b0;
        rlr     = 1'b0;
        rr      = hold_rd;
        pa      = BA'($urandom);
        wt_data = 8'($urandom);
      end
    end
  endtask

  initial begin
    int kind, w, eb;
    wtr = 1'b0; rr = 1'b0; rlr = 1'b0; pa = '0; wt_data = '0;
    bus.bus_ack = 1'b0; bus.hready = 1'b0; bus.hresp = 1'b0; bus.hrdata = '0;

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    chk("hreset_n_in_reset", 32'(bus.hreset_n), 32'd0);
    rst = 1'b0;
    #1;
    chk("hreset_n_run", 32'(bus.hreset_n), 32'd1);

    // Single read returning 0xA5.
    rd_fixed = 8'hA5;
    run_xfer(KRead, 24'h123456, 8'h00, 0, 0, -1, 1'b0);
    rd_fixed = -1;
    // Write-through.
    run_xfer(KWrite, 24'h000010, 8'h3C, 0, 0, -1, 1'b0);
    // Full line read, unaligned start address.
    run_xfer(KLine, 24'h001237, 8'h00, 0, 0, -1, 1'b0);
    // Grant delayed 3 cycles, two stalls in ADDR and in DATA.
    run_xfer(KRead, 24'h00ABCD, 8'h00, 3, 2, -1, 1'b0);
    run_xfer(KWrite, 24'h0F0F0F, 8'h81, 3, 2, -1, 1'b0);
    // Error response on beat 1 of a line read.
    run_xfer(KLine, 24'h004440, 8'h00, 0, 0, 1, 1'b0);
    // Write and read raised together: write first, then the held read.
    run_xfer(KWrite, 24'h000200, 8'h77, 0, 0, -1, 1'b1);
    run_xfer(KRead, 24'h000300, 8'h00, 0, 0, -1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 2));
      w    = int'($urandom_range(0, 3));
      eb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MB - 1)) : -1;
      run_xfer(kind, BA'($urandom), 8'($urandom), w, 1, eb, 1'b0);
    end

    // Reset in the middle of a burst.
    @(negedge clk);
    pa = 24'h00AA00; rlr = 1'b1; bus.bus_ack = 1'b1; bus.hready = 1'b1; bus.hresp = 1'b0;
    bus.hrdata = 8'h5A;
    repeat (4) @(negedge clk);
    chk("midburst_line_data", 32'(line_data), 32'h5A);
    rst = 1'b1;
    #1;
    chk("midburst_hreset_n", 32'(bus.hreset_n), 32'd0);
    @(negedge clk);
    chk_all_zero("midburst_reset");
    rst = 1'b0;
    rlr = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("post_reset_trans_rdy", 32'(trans_rdy), 32'd0);
      chk("post_reset_bus_req", 32'(bus.bus_req), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
